// File: rtl/msg_serializer.sv
// msg_serializer: splits one message into AXI-Stream beats; MSG_SERIALIZER_STATS_EN adds sent/errored message counters
module msg_serializer #(
  parameter int MAX_MSG_BYTES = 32,
  parameter int DATA_BYTES    = 8,
  parameter int LEN_W         = $clog2(MAX_MSG_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       msg_error,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  output logic [8*DATA_BYTES-1:0]    m_tdata,
  output logic [DATA_BYTES-1:0]      m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [15:0]                stat_msgs,
  output logic [15:0]                stat_errs
);
  localparam int NB = MAX_MSG_BYTES / DATA_BYTES;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [8*MAX_MSG_BYTES-1:0] msg_q;
  logic [LEN_W-1:0] len_q, len_eff;
  logic err_q, hs, acc, load;
  logic [IW-1:0] idx, idx_n;
  int rem;
  assign len_eff = msg_len > LEN_W'(MAX_MSG_BYTES) ? LEN_W'(MAX_MSG_BYTES) : msg_len;
  assign m_tvalid = state == SEND;
  assign hs = m_tvalid && m_tready;
  assign msg_ready = state == IDLE || (hs && m_tlast);
  assign acc = msg_valid && msg_ready;
  assign load = acc && len_eff != '0;
  // rem is the count of captured bytes from the current beat onward
  always_comb begin
    rem = int'(len_q) - int'(idx) * DATA_BYTES;
    m_tkeep = '0;
    m_tdata = '0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      m_tkeep[b] = m_tvalid && b < rem;
      m_tdata[8*b +: 8] = m_tkeep[b] ? msg_q[8*(int'(idx)*DATA_BYTES + b) +: 8] : 8'h00;
    end
  end
  assign m_tlast = m_tvalid && rem <= DATA_BYTES;
  assign m_tuser = m_tlast && err_q;
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (load) begin
      state_n = SEND;
      idx_n = '0;
    end else if (hs && m_tlast) begin
      state_n = IDLE;
      idx_n = '0;
    end else if (hs) idx_n = idx + 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      msg_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (load) begin
        msg_q <= msg_data;
        len_q <= len_eff;
        err_q <= msg_error;
      end
    end
`ifdef MSG_SERIALIZER_STATS_EN
  logic [15:0] msgs_q, errs_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      msgs_q <= '0;
      errs_q <= '0;
    end else if (hs && m_tlast) begin
      if (msgs_q != 16'hFFFF) msgs_q <= msgs_q + 1'b1;
      if (m_tuser && errs_q != 16'hFFFF) errs_q <= errs_q + 1'b1;
    end
  assign stat_msgs = msgs_q;
  assign stat_errs = errs_q;
`else
  assign stat_msgs = '0;
  assign stat_errs = '0;
`endif
endmodule

// File: tb/tb_msg_serializer.sv
// tb_msg_serializer: random-data directed and random scenarios against a byte-level framing model
module tb_msg_serializer;
  localparam int MB = 32;
  localparam int DB = 8;
  localparam int LW = $clog2(MB + 1);
  typedef struct {logic [8*DB-1:0] d; logic [DB-1:0] k; logic l; logic u;} beat_t;
  logic clk = 0, rst = 1;
  logic [8*MB-1:0] msg_data = '0;
  logic [LW-1:0] msg_len = '0;
  logic msg_error = 0, msg_valid = 0, m_tready = 1;
  logic msg_ready, m_tlast, m_tuser, m_tvalid;
  logic [8*DB-1:0] m_tdata;
  logic [DB-1:0] m_tkeep;
  logic [15:0] stat_msgs, stat_errs;
  int checks = 0, failures = 0;
  beat_t q[$];
  beat_t prev;
  bit stall_prev = 0, accepted = 0, rnd_rdy = 0;
  int exp_msgs = 0, exp_errs = 0;

  msg_serializer #(.MAX_MSG_BYTES(MB), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst), .msg_data(msg_data), .msg_len(msg_len), .msg_error(msg_error),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .stat_msgs(stat_msgs), .stat_errs(stat_errs));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_push(input logic [8*MB-1:0] data, input int len, input logic err);
    int l = len > MB ? MB : len;
    int n = (l + DB - 1) / DB;
    for (int k = 0; k < n; k++) begin
      beat_t e;
      e.d = '0;
      e.k = '0;
      for (int b = 0; b < DB; b++)
        if (k * DB + b < l) begin
          e.d[8*b +: 8] = data[8*(k*DB + b) +: 8];
          e.k[b] = 1'b1;
        end
      e.l = k == n - 1;
      e.u = e.l && err;
      q.push_back(e);
    end
  endfunction

  function automatic int expect_stat(input int v);
`ifdef MSG_SERIALIZER_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // called just after a falling edge with inputs set; evaluates the cycle and advances to the next falling edge
  task automatic tick();
    #1;
    chk("tvalid", m_tvalid, q.size() != 0);
    chk("msg_ready", msg_ready, q.size() == 0 || (q.size() == 1 && m_tready));
    chk("stat_msgs", stat_msgs, expect_stat(exp_msgs));
    chk("stat_errs", stat_errs, expect_stat(exp_errs));
    if (stall_prev) chk("held", {m_tdata, m_tkeep, m_tlast, m_tuser}, {prev.d, prev.k, prev.l, prev.u});
    if (m_tvalid && m_tready && q.size() != 0) begin
      beat_t e = q.pop_front();
      chk("tdata", m_tdata, e.d);
      chk("tkeep", m_tkeep, e.k);
      chk("tlast", m_tlast, e.l);
      chk("tuser", m_tuser, e.u);
      if (e.l) begin
        if (exp_msgs < 16'hFFFF) exp_msgs++;
        if (e.u && exp_errs < 16'hFFFF) exp_errs++;
      end
    end
    stall_prev = m_tvalid && !m_tready;
    prev = '{m_tdata, m_tkeep, m_tlast, m_tuser};
    accepted = msg_valid && msg_ready;
    if (accepted) model_push(msg_data, int'(msg_len), msg_error);
    @(negedge clk);
  endtask

  task automatic set_rdy();
    m_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic send(input int len, input logic err, input bit ramp);
    for (int i = 0; i < MB; i++) msg_data[8*i +: 8] = ramp ? 8'(i) : 8'($urandom);
    msg_len = LW'(len);
    msg_error = err;
    msg_valid = 1;
    accepted = 0;
    for (int t = 0; t < 200 && !accepted; t++) begin
      set_rdy();
      tick();
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    msg_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && q.size() != 0; t++) begin
      set_rdy();
      tick();
    end
    chk("drain_empty", q.size(), 0);
    m_tready = 1;
    tick();
  endtask

  initial begin
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tlast_tuser", {m_tlast, m_tuser}, 0);
    chk("rst_ready", msg_ready, 1);
    chk("rst_stats", {stat_msgs, stat_errs}, 0);
    @(negedge clk);
    rst = 0;
    send(32, 0, 1);
    drain();
    send(11, 0, 0);
    drain();
    send(24, 0, 0);
    m_tready = 1;
    tick();
    m_tready = 0;
    repeat (3) tick();
    drain();
    send(5, 1, 0);
    drain();
    send(8, 0, 0);
    send(8, 1, 0);
    drain();
    send(40, 0, 0);
    drain();
    send(0, 1, 0);
    drain();
    send(32, 1, 0);
    m_tready = 1;
    tick();
    #2 rst = 1;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_ready", msg_ready, 1);
    chk("midrst_stats", {stat_msgs, stat_errs}, 0);
    q.delete();
    stall_prev = 0;
    exp_msgs = 0;
    exp_errs = 0;
    @(negedge clk);
    rst = 0;
    send(19, 1, 0);
    drain();
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 40), 1'($urandom), 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
